din_syn_rx: RTL
===============

// Module: din_syn_rx
// PURPOSE
//  Serial frame receiver/checker for the clk/dout/syn pattern-generator interface.
//  - Oversamples the external sclk/sdin/ssyn pins in the clk_in domain.
//  - Captures one frame: bit k is sampled on the k-th sclk rise into frame_data[k]; the first bit sent is bit 0.
//  - Closes the frame on the ssyn rise.
//  - Used for FPGA loopback self-test and for readback of daisy-chained control registers.
// PARAMETERS
//  MAX_BITS     1024  capture register depth (bits)
//  CNT_W        11    bit-counter width; must hold MAX_BITS
//  SYNC_STAGES  2     metastability flops per input pin (>=2)
// PORTS
//  clk_in       in   1         system clock; must be >= 4x the sclk frequency
//  rst_n        in   1         asynchronous reset, active low
//  sclk         in   1         serial clock pin, asynchronous to clk_in
//  sdin         in   1         serial data pin; stable around each sclk rise
//  ssyn         in   1         end-of-frame strobe pin, active high
//  arm          in   1         1-cycle pulse: start waiting for a frame
//  seq_length   in   10        expected bit count (0 = 1024)
//  busy         out  1         high in WAIT or RECV
//  frame_valid  out  1         1-cycle pulse when a frame closes
//  frame_data   out  MAX_BITS  captured bits; held until the next frame closes
//  frame_len    out  CNT_W     number of bits captured in the last frame
//  len_err      out  1         frame_len != expected length; valid with frame_valid, held
//  overflow     out  1         more than MAX_BITS edges arrived; sticky until arm
// BEHAVIOUR
//  Reset: all outputs are 0 and state=IDLE. Reset mid-frame discards the partial frame.
//  Input path: each pin goes through a SYNC_STAGES flop chain plus one edge flop.
//   - rise = synced & ~prev.
//   - sdin gets the same delay as sclk, so it is sampled in the same cycle the sclk rise is detected.
//  State IDLE
//   - arm -> WAIT; clears the bit counter and overflow.
//   - sclk and ssyn rises are ignored.
//  State WAIT
//   - first sclk rise -> RECV and captures bit 0.
//   - ssyn rise -> DONE with frame_len=0.
//   - arm is ignored.
//  State RECV, on each sclk rise:
//   - if cnt < MAX_BITS: shift_reg[cnt] <= sdin and cnt++.
//   - otherwise set overflow and drop the bit; cnt saturates.
//   - ssyn rise -> DONE.
//  State DONE (1 cycle)
//   - Transfers shift_reg to frame_data and cnt to frame_len.
//   - Pulses frame_valid and updates len_err.
//   - Then goes to IDLE. busy=0.
//  Same-cycle sclk rise and ssyn rise: the bit is captured first, then the frame closes with it included.
//  Expected length: {seq_length==0, seq_length}, zero-extended to CNT_W.
//  Arm in DONE is ignored; the caller re-arms after frame_valid.
//  Latency: frame_valid is asserted SYNC_STAGES+2 clk_in cycles after the ssyn pin rises.
//  Held pins (generator clear mode: sclk gated off, ssyn=0) produce no events; state is unchanged.
// CONFIGURATION
//  DIN_SYN_RX_COMPARE_EN defined:
//   - Adds input ref_data[MAX_BITS], output mismatch (1), output mismatch_cnt (CNT_W).
//   - In DONE: mismatch_cnt = popcount((shift_reg ^ ref_data) masked to the low frame_len bits).
//   - mismatch = (mismatch_cnt != 0) | len_err.
//   - Registered with frame_valid.
//   - The popcount may be pipelined; if it is, frame_valid is delayed by the same depth.
//  Not defined: none of these ports exist; no compare logic.
// STRUCTURE
//  Package din_syn_pkg:
//   - state encoding (IDLE, WAIT, RECV, DONE)
//   - defaults for MAX_BITS, CNT_W, SYNC_STAGES
//   - function exp_len(seq_length)
//  Sub-module din_syn_edge_sync (SYNC_STAGES chain + rise detect):
//   - instanced for sclk and ssyn
//   - sdin uses the same chain without the rise output
// TESTING
//  - Length 451, pattern {451 bits alternating 1/0}: frame_valid once; frame_len=451; frame_data[450:0] matches; len_err=0.
//  - seq_length=451 but only 450 sclk rises before ssyn: frame_len=450; len_err=1.
//  - 1030 sclk rises, seq_length=0: overflow=1; frame_len=1024; bits 1024..1029 dropped; len_err=0.
//  - ssyn rise in the same clk_in cycle as the 8th sclk rise: frame_len=8; bit 7 captured.
//  - rst_n low after 100 bits, then arm plus a 16-bit frame: only 16 bits captured; no stale frame_valid.
//  - COMPARE_EN, ref_data = sent data with bits 3 and 200 flipped, length 451: mismatch_cnt=2; mismatch=1.

Source files
------------

// File: rtl/din_syn_pkg.sv
// Shared state encoding, default sizing and the expected-length helper for the din_syn receiver.
package din_syn_pkg;

    localparam int DEF_MAX_BITS    = 1024;
    localparam int DEF_CNT_W       = 11;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RECV,
        ST_DONE
    } state_e;

    // A seq_length of zero encodes a full 1024-bit frame.
    function automatic logic [10:0] exp_len(input logic [9:0] seq_length);
        return {seq_length == 10'd0, seq_length};
    endfunction

endpackage

// File: rtl/din_syn_edge_sync.sv
// Synchronizer chain for one asynchronous pin plus an edge flop that flags synchronized rising edges.
module din_syn_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic pin_i,
    output logic sync_o,
    output logic rise_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], pin_i};
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign sync_o = chain_q[STAGES-1];
    assign rise_o = chain_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/din_syn_rx.sv
// Serial frame receiver for the sclk/sdin/ssyn pattern-generator interface.
// Define DIN_SYN_RX_COMPARE_EN to add the reference-data comparison (ref_data, mismatch, mismatch_cnt).
module din_syn_rx
    import din_syn_pkg::*;
#(
    parameter int MAX_BITS    = DEF_MAX_BITS,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                sclk,
    input  logic                sdin,
    input  logic                ssyn,
    input  logic                arm,
    input  logic [9:0]          seq_length,
`ifdef DIN_SYN_RX_COMPARE_EN
    input  logic [MAX_BITS-1:0] ref_data,
    output logic                mismatch,
    output logic [CNT_W-1:0]    mismatch_cnt,
`endif
    output logic                busy,
    output logic                frame_valid,
    output logic [MAX_BITS-1:0] frame_data,
    output logic [CNT_W-1:0]    frame_len,
    output logic                len_err,
    output logic                overflow
);

    localparam int IDX_W = $clog2(MAX_BITS);

    logic sclk_rise;
    logic ssyn_rise;
    logic sdin_s;
    logic sclk_sync_unused;
    logic ssyn_sync_unused;
    logic sdin_rise_unused;

    din_syn_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .pin_i  (sclk),
        .sync_o (sclk_sync_unused),
        .rise_o (sclk_rise)
    );

    din_syn_edge_sync #(.STAGES(SYNC_STAGES)) u_ssyn_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .pin_i  (ssyn),
        .sync_o (ssyn_sync_unused),
        .rise_o (ssyn_rise)
    );

    // sdin shares the sclk latency so its value lines up with the detected sclk rise.
    din_syn_edge_sync #(.STAGES(SYNC_STAGES)) u_sdin_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .pin_i  (sdin),
        .sync_o (sdin_s),
        .rise_o (sdin_rise_unused)
    );

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MAX_BITS-1:0] shift_q, shift_d;
    logic                overflow_q, overflow_d;
    logic                frame_valid_q, frame_valid_d;
    logic [MAX_BITS-1:0] frame_data_q, frame_data_d;
    logic [CNT_W-1:0]    frame_len_q, frame_len_d;
    logic                len_err_q, len_err_d;
    logic [CNT_W-1:0]    exp_len_w;

    assign exp_len_w = CNT_W'(exp_len(seq_length));

`ifdef DIN_SYN_RX_COMPARE_EN
    logic [CNT_W-1:0]    mm_cnt_q, mm_cnt_d, mm_pop;
    logic                mismatch_q, mismatch_d;
    logic [MAX_BITS-1:0] diff;

    always_comb begin
        diff   = shift_q ^ ref_data;
        mm_pop = '0;
        for (int i = 0; i < MAX_BITS; i++) begin
            if (diff[i] && (i < int'(cnt_q))) begin
                mm_pop = mm_pop + CNT_W'(1);
            end
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        overflow_d    = overflow_q;
        frame_valid_d = 1'b0;
        frame_data_d  = frame_data_q;
        frame_len_d   = frame_len_q;
        len_err_d     = len_err_q;
`ifdef DIN_SYN_RX_COMPARE_EN
        mm_cnt_d      = mm_cnt_q;
        mismatch_d    = mismatch_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d    = ST_WAIT;
                    cnt_d      = '0;
                    shift_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            // A bit arriving with ssyn is stored before the frame closes.
            ST_WAIT, ST_RECV: begin
                if (sclk_rise) begin
                    state_d = ST_RECV;
                    if (cnt_q < CNT_W'(MAX_BITS)) begin
                        shift_d[cnt_q[IDX_W-1:0]] = sdin_s;
                        cnt_d                     = cnt_q + CNT_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (ssyn_rise) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d       = ST_IDLE;
                frame_valid_d = 1'b1;
                frame_data_d  = shift_q;
                frame_len_d   = cnt_q;
                len_err_d     = (cnt_q != exp_len_w);
`ifdef DIN_SYN_RX_COMPARE_EN
                mm_cnt_d      = mm_pop;
                mismatch_d    = (mm_pop != '0) | (cnt_q != exp_len_w);
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            overflow_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_data_q  <= '0;
            frame_len_q   <= '0;
            len_err_q     <= 1'b0;
`ifdef DIN_SYN_RX_COMPARE_EN
            mm_cnt_q      <= '0;
            mismatch_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            overflow_q    <= overflow_d;
            frame_valid_q <= frame_valid_d;
            frame_data_q  <= frame_data_d;
            frame_len_q   <= frame_len_d;
            len_err_q     <= len_err_d;
`ifdef DIN_SYN_RX_COMPARE_EN
            mm_cnt_q      <= mm_cnt_d;
            mismatch_q    <= mismatch_d;
`endif
        end
    end

    assign busy        = (state_q == ST_WAIT) || (state_q == ST_RECV);
    assign frame_valid = frame_valid_q;
    assign frame_data  = frame_data_q;
    assign frame_len   = frame_len_q;
    assign len_err     = len_err_q;
    assign overflow    = overflow_q;
`ifdef DIN_SYN_RX_COMPARE_EN
    assign mismatch     = mismatch_q;
    assign mismatch_cnt = mm_cnt_q;
`endif

endmodule
